// File: rtl/rvcpu_pkg.sv
// rvcpu: shared types for the CPU pipeline stages.
// Holds the execute-to-memory and memory-to-writeback bundles.
// Also holds the memory-op encodings, the stage_mem FSM states and
// the alignment helper used by the memory stage.
package rvcpu;

    localparam int Width = 32;

    typedef logic [Width-1:0] data_t;
    typedef logic [Width-1:0] pc_t;
    typedef logic [4:0]       reg_t;

    typedef struct packed {
        data_t res;
        pc_t   pc;
    } stage_ex_t;

    typedef enum logic [1:0] {
        mem_none,
        mem_load,
        mem_store
    } mem_op_t;

    typedef enum logic [1:0] {
        size_byte,
        size_half,
        size_word
    } mem_size_t;

    typedef struct packed {
        pc_t   pc;
        reg_t  rd;
        logic  rd_valid;
        data_t data;
        logic  fault;
    } stage_mem_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } mem_state_t;

    // Byte accesses can never be misaligned. Halves need an even address,
    // and words need a 4-byte aligned address.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
        case (size)
            size_byte: return 1'b0;
            size_half: return offset[0];
            default:   return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/stage_mem_load_formatter.sv
// load_formatter: purely combinational lane extraction for loads.
// Ports:
//   rdata       - full 32-bit word returned by data memory
//   offset      - byte offset of the access inside that word
//   size        - access size (byte / half / word)
//   is_unsigned - zero-extend instead of sign-extend
//   data        - formatted value for the destination register
module load_formatter
    import rvcpu::*;
(
    input  data_t       rdata,
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output data_t       data
);

    logic [15:0] lane;
    logic        sign_b;
    logic        sign_h;

    // Shift the addressed byte down to bit 0.
    // Only the low 16 bits of the shifted word can ever be returned.
    always_comb begin
        lane   = 16'(rdata >> {offset, 3'b000});
        sign_b = ~is_unsigned & lane[7];
        sign_h = ~is_unsigned & lane[15];
        data   = rdata;
        case (size)
            size_byte: data = {{24{sign_b}}, lane[7:0]};
            size_half: data = {{16{sign_h}}, lane[15:0]};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: pipeline memory stage between execute and writeback.
// It accepts one execute bundle at a time. An aligned load or store
// issues a single data-memory request; other bundles pass straight
// through. The stage then presents one writeback bundle.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   in_valid/in_ready        - execute bundle handshake
//   ex, rd, rd_valid         - execute result and destination register
//   store_data, mem_op,
//   mem_size, mem_unsigned   - memory-op side information
//   dmem_req_*/dmem_addr/
//   dmem_we/dmem_wdata/
//   dmem_wstrb               - data-memory request channel
//   dmem_rsp_valid/rdata     - data-memory load response channel
//   out_valid/out_ready/out  - writeback bundle handshake
module stage_mem
    import rvcpu::*;
#(
    parameter int Width = rvcpu::Width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  stage_ex_t        ex,
    input  reg_t             rd,
    input  logic             rd_valid,
    input  logic [Width-1:0] store_data,
    input  mem_op_t          mem_op,
    input  mem_size_t        mem_size,
    input  logic             mem_unsigned,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic [Width-1:0] dmem_addr,
    output logic             dmem_we,
    output logic [Width-1:0] dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    input  logic             dmem_rsp_valid,
    input  logic [Width-1:0] dmem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output stage_mem_t       out
);

    mem_state_t state;
    mem_state_t state_next;
    mem_state_t dispatch_state;

    logic       in_accept;
    logic       mem_access;
    logic       misaligned;

    data_t      wdata_fmt;
    logic [3:0] wstrb_fmt;

    data_t      res_q;
    pc_t        pc_q;
    reg_t       rd_q;
    logic       rd_valid_q;
    logic       we_q;
    data_t      wdata_q;
    logic [3:0] wstrb_q;
    mem_size_t  size_q;
    logic       unsigned_q;
    stage_mem_t out_q;
    data_t      load_data;

    // A new bundle can enter when the stage is empty. It can also enter
    // when the current result leaves in this same cycle, which is the
    // back-to-back case.
    assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
    assign in_accept  = in_valid && in_ready;
    assign mem_access = (mem_op == mem_load) || (mem_op == mem_store);
    assign misaligned = mem_access && is_misaligned(mem_size, ex.res[1:0]);

    // Only aligned memory ops go to the bus.
    // Pass-through bundles and faulting bundles finish immediately.
    always_comb begin
        dispatch_state = DONE;
        if (mem_access && !misaligned) begin
            dispatch_state = REQ;
        end
    end

    // Replicate the store data across every lane it could land in.
    // The strobe then selects the lane that is actually written.
    always_comb begin
        wdata_fmt = store_data;
        wstrb_fmt = 4'b1111;
        case (mem_size)
            size_byte: begin
                wdata_fmt = {4{store_data[7:0]}};
                wstrb_fmt = 4'b0001 << ex.res[1:0];
            end
            size_half: begin
                wdata_fmt = {2{store_data[15:0]}};
                wstrb_fmt = 4'b0011 << ex.res[1:0];
            end
            default: begin
                wdata_fmt = store_data;
                wstrb_fmt = 4'b1111;
            end
        endcase
        if (mem_op != mem_store) begin
            wstrb_fmt = 4'b0000;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_accept) begin
                    state_next = dispatch_state;
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    state_next = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_rsp_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = in_accept ? dispatch_state : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The request fields only change on acceptance. Acceptance cannot
    // happen in REQ, so the bus sees stable values for the whole
    // backpressure window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q      <= '0;
            pc_q       <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            size_q     <= size_byte;
            unsigned_q <= 1'b0;
            out_q      <= '0;
        end else if (in_accept) begin
            res_q      <= ex.res;
            pc_q       <= ex.pc;
            rd_q       <= rd;
            rd_valid_q <= rd_valid && (mem_op != mem_store);
            we_q       <= (mem_op == mem_store);
            wdata_q    <= wdata_fmt;
            wstrb_q    <= wstrb_fmt;
            size_q     <= mem_size;
            unsigned_q <= mem_unsigned;
            if (dispatch_state == DONE) begin
                out_q <= '{pc: ex.pc, rd: rd, rd_valid: rd_valid && !misaligned,
                           data: ex.res, fault: misaligned};
            end
        end else if (state == REQ && dmem_req_ready && we_q) begin
            out_q <= '{pc: pc_q, rd: rd_q, rd_valid: 1'b0, data: res_q, fault: 1'b0};
        end else if (state == WAIT && dmem_rsp_valid) begin
            out_q <= '{pc: pc_q, rd: rd_q, rd_valid: rd_valid_q, data: load_data, fault: 1'b0};
        end
    end

    load_formatter u_load_formatter (
        .rdata       (dmem_rdata),
        .offset      (res_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (load_data)
    );

    assign dmem_req_valid = (state == REQ);
    assign dmem_addr      = {res_q[Width-1:2], 2'b00};
    assign dmem_we        = we_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_wstrb     = wstrb_q;
    assign out_valid      = (state == DONE);
    assign out            = out_q;

endmodule
